// File: rtl/fft_pkg.sv
// Shared definitions for the FFT spectrum blocks: bin count, index width,
// default sample width, frame-tracking state and index helpers.
package fft_pkg;

    localparam int N_BINS    = 8;
    localparam int IDX_W     = $clog2(N_BINS);
    localparam int W_DEFAULT = 8;

    localparam logic [IDX_W-1:0] IDX_FIRST = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST  = {IDX_W{1'b1}};

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Next expected bin; the 3-bit wrap makes 0 follow 7.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/fft_peak_detect_if.sv
// Bin stream in / peak report out bundle for fft_peak_detect.
// master = stream source and report consumer, slave = the detector.
interface fft_peak_detect_if
    import fft_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int MAG_W = 2*W+1
);
    logic signed [W-1:0]     in_re;
    logic signed [W-1:0]     in_im;
    logic        [IDX_W-1:0] in_index;
    logic        [IDX_W-1:0] peak_index;
    logic        [MAG_W-1:0] peak_mag;
    logic                    peak_valid;
    logic                    frame_err;

    modport master (
        output in_re, in_im, in_index,
        input  peak_index, peak_mag, peak_valid, frame_err
    );

    modport slave (
        input  in_re, in_im, in_index,
        output peak_index, peak_mag, peak_valid, frame_err
    );

endinterface

// File: rtl/fft_mag_sq.sv
// Registered squared magnitude re^2+im^2 with a tag and valid carried alongside.
// Magnitude and tag hold their last value while in_valid is low.
module fft_mag_sq #(
    parameter int W     = 8,
    parameter int MAG_W = 2*W+1,
    parameter int TAG_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    output logic [MAG_W-1:0]    out_mag,
    output logic [TAG_W-1:0]    out_tag
);

    logic signed [2*W-1:0] re_ext_s;
    logic signed [2*W-1:0] im_ext_s;
    logic        [2*W-1:0] re_sq_s;
    logic        [2*W-1:0] im_sq_s;
    logic                  valid_d, valid_q;
    logic [MAG_W-1:0]      mag_d, mag_q;
    logic [TAG_W-1:0]      tag_d, tag_q;

    // Full-precision squares: each fits 2W bits even for the most negative input.
    always_comb begin
        re_ext_s = {{W{in_re[W-1]}}, in_re};
        im_ext_s = {{W{in_im[W-1]}}, in_im};
        re_sq_s  = $unsigned(re_ext_s * re_ext_s);
        im_sq_s  = $unsigned(im_ext_s * im_ext_s);
        valid_d  = in_valid;
        if (in_valid) begin
            mag_d = MAG_W'(re_sq_s) + MAG_W'(im_sq_s);
            tag_d = in_tag;
        end else begin
            mag_d = mag_q;
            tag_d = tag_q;
        end
    end

    // Result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            mag_q   <= {MAG_W{1'b0}};
            tag_q   <= {TAG_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            mag_q   <= mag_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q;
    assign out_mag   = mag_q;
    assign out_tag   = tag_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Peak-bin detector for the serialized 8-point FFT stream; reports the strongest
// bin per frame. Define FFT_PEAK_HALF_SPECTRUM_EN to exclude mirror bins 5..7.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int MAG_W = 2*W+1
) (
    input logic              fastclk,
    input logic              rst,
    fft_peak_detect_if.slave bus
);

    logic [IDX_W-1:0] idx_d, idx_q;
    logic             accept_s;
    logic             v1_s;
    logic [MAG_W-1:0] mag_s;
    logic [IDX_W-1:0] bin_s;
    logic             compare_en_s;

    state_t           state_d, state_q;
    logic [IDX_W-1:0] expect_d, expect_q;
    logic [MAG_W-1:0] best_mag_d, best_mag_q;
    logic [IDX_W-1:0] best_idx_d, best_idx_q;
    logic [IDX_W-1:0] peak_index_d, peak_index_q;
    logic [MAG_W-1:0] peak_mag_d, peak_mag_q;
    logic             peak_valid_d, peak_valid_q;
    logic             frame_err_d, frame_err_q;

    // A bin is new whenever the index differs from the last one taken.
    always_comb begin
        accept_s = (bus.in_index != idx_q);
        if (accept_s) begin
            idx_d = bus.in_index;
        end else begin
            idx_d = idx_q;
        end
    end

    // Last accepted index; reset to 7 so a held 0 after reset starts a frame.
    always_ff @(posedge fastclk) begin
        if (rst) begin
            idx_q <= IDX_LAST;
        end else begin
            idx_q <= idx_d;
        end
    end

    fft_mag_sq #(
        .W     (W),
        .MAG_W (MAG_W),
        .TAG_W (IDX_W)
    ) u_mag_sq (
        .clk       (fastclk),
        .rst       (rst),
        .in_valid  (accept_s),
        .in_re     (bus.in_re),
        .in_im     (bus.in_im),
        .in_tag    (bus.in_index),
        .out_valid (v1_s),
        .out_mag   (mag_s),
        .out_tag   (bin_s)
    );

`ifdef FFT_PEAK_HALF_SPECTRUM_EN
    assign compare_en_s = (bin_s <= 3'd4);
`else
    assign compare_en_s = 1'b1;
`endif

    // Frame tracking and running maximum; strict compare keeps the lower index on ties.
    always_comb begin
        state_d      = state_q;
        expect_d     = expect_q;
        best_mag_d   = best_mag_q;
        best_idx_d   = best_idx_q;
        peak_index_d = peak_index_q;
        peak_mag_d   = peak_mag_q;
        peak_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (v1_s) begin
            if (bin_s == IDX_FIRST) begin
                state_d     = ACCUM;
                expect_d    = next_idx(bin_s);
                best_mag_d  = mag_s;
                best_idx_d  = IDX_FIRST;
                frame_err_d = (state_q == ACCUM) && (expect_q != IDX_FIRST);
            end else if (state_q == ACCUM) begin
                if (bin_s == expect_q) begin
                    expect_d = next_idx(bin_s);
                    if (compare_en_s && (mag_s > best_mag_q)) begin
                        best_mag_d = mag_s;
                        best_idx_d = bin_s;
                    end else begin
                        best_mag_d = best_mag_q;
                        best_idx_d = best_idx_q;
                    end
                    if (bin_s == IDX_LAST) begin
                        peak_index_d = best_idx_d;
                        peak_mag_d   = best_mag_d;
                        peak_valid_d = 1'b1;
                    end else begin
                        peak_valid_d = 1'b0;
                    end
                end else begin
                    state_d     = SYNC;
                    frame_err_d = 1'b1;
                end
            end else begin
                state_d = SYNC;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Frame state, running best and registered report outputs.
    always_ff @(posedge fastclk) begin
        if (rst) begin
            state_q      <= SYNC;
            expect_q     <= IDX_FIRST;
            best_mag_q   <= {MAG_W{1'b0}};
            best_idx_q   <= IDX_FIRST;
            peak_index_q <= IDX_FIRST;
            peak_mag_q   <= {MAG_W{1'b0}};
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            expect_q     <= expect_d;
            best_mag_q   <= best_mag_d;
            best_idx_q   <= best_idx_d;
            peak_index_q <= peak_index_d;
            peak_mag_q   <= peak_mag_d;
            peak_valid_q <= peak_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.peak_index = peak_index_q;
    assign bus.peak_mag   = peak_mag_q;
    assign bus.peak_valid = peak_valid_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: frame-level reference model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_fft_peak_detect;
    import fft_pkg::*;

    localparam int W     = W_DEFAULT;
    localparam int MAG_W = 2*W+1;
`ifdef FFT_PEAK_HALF_SPECTRUM_EN
    localparam int CMP_LAST = 4;
`else
    localparam int CMP_LAST = 7;
`endif

    logic fastclk = 1'b0;
    logic rst     = 1'b1;

    fft_peak_detect_if #(.W(W), .MAG_W(MAG_W)) bus ();

    fft_peak_detect #(.W(W), .MAG_W(MAG_W)) dut (
        .fastclk (fastclk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 fastclk = ~fastclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    bit checking  = 1'b0;

    always @(posedge fastclk) cyc <= cyc + 1;

    typedef struct {
        int     at;
        int     kind;   // 0 reset, 1 peak report, 2 sequence error
        int     idx;
        longint mag;
    } ev_t;
    ev_t evq[$];

    // Frame-level model state
    int     m_last_idx = 7;
    bit     m_in_frame = 1'b0;
    int     m_expect   = 0;
    longint m_mag[8];

    int     exp_idx   = 0;
    longint exp_mag   = 0;
    bit     exp_valid = 1'b0;
    bit     exp_err   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int at, input int kind, input int idx, input longint mag);
        ev_t e;
        e.at = at; e.kind = kind; e.idx = idx; e.mag = mag;
        evq.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].at >= cyc + 1) evq.delete(i);
        end
        push_ev(cyc + 1, 0, 0, 0);
        m_last_idx = 7;
        m_in_frame = 1'b0;
        checking   = 1'b1;
    endtask

    // Frame rules applied to one accepted bin; report lands two edges after acceptance.
    task automatic model_accept(input int idx, input longint mag);
        int     best_i;
        longint best_m;
        m_last_idx = idx;
        if (idx == 0) begin
            if (m_in_frame && m_expect != 0) push_ev(cyc + 2, 2, 0, 0);
            m_in_frame = 1'b1;
            for (int b = 0; b < 8; b++) m_mag[b] = 0;
            m_mag[0] = mag;
            m_expect = 1;
        end else if (m_in_frame) begin
            if (idx == m_expect) begin
                m_mag[idx] = mag;
                m_expect = (idx + 1) % 8;
                if (idx == 7) begin
                    best_i = 0;
                    best_m = -1;
                    for (int b = 0; b <= CMP_LAST; b++) begin
                        if (m_mag[b] > best_m) begin
                            best_m = m_mag[b];
                            best_i = b;
                        end
                    end
                    push_ev(cyc + 2, 1, best_i, best_m);
                end
            end else begin
                push_ev(cyc + 2, 2, 0, 0);
                m_in_frame = 1'b0;
            end
        end
    endtask

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge fastclk) begin
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].at == cyc) begin
                case (evq[i].kind)
                    0: begin exp_idx = 0; exp_mag = 0; end
                    1: begin exp_idx = evq[i].idx; exp_mag = evq[i].mag; exp_valid = 1'b1; end
                    default: exp_err = 1'b1;
                endcase
                evq.delete(i);
            end
        end
        if (bus.peak_valid === 1'b1) valid_cnt++;
        if (bus.frame_err === 1'b1) err_cnt++;
        if (checking) begin
            check("cyc_peak_index", 64'(bus.peak_index), 64'(exp_idx));
            check("cyc_peak_mag",   64'(bus.peak_mag),   64'(exp_mag));
            check("cyc_peak_valid", 64'(bus.peak_valid), 64'(exp_valid));
            check("cyc_frame_err",  64'(bus.frame_err),  64'(exp_err));
        end
    end

    task automatic step(input bit r, input int idx, input int re, input int im);
        rst          = r;
        bus.in_index = idx[2:0];
        bus.in_re    = re[W-1:0];
        bus.in_im    = im[W-1:0];
        if (r) model_reset();
        else if (idx != m_last_idx) model_accept(idx, longint'(re * re + im * im));
        @(posedge fastclk);
        #1;
    endtask

    task automatic send(input int idx, input int re, input int im, input int hold);
        for (int i = 0; i < hold; i++) step(1'b0, idx, re, im);
    endtask

    task automatic send_frame(input int re[8], input int im[8], input int hold);
        for (int b = 0; b < 8; b++) send(b, re[b], im[b], hold);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge fastclk);
            #1;
        end
    endtask

    int re_v[8];
    int im_v[8];
    int v0, e0;

    initial begin
        bus.in_index = 3'd7;
        bus.in_re    = '0;
        bus.in_im    = '0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 7, 0, 0);
        send(7, 0, 0, 2);
        check("reset_peak_index", 64'(bus.peak_index), 64'd0);
        check("reset_peak_mag",   64'(bus.peak_mag),   64'd0);
        check("reset_peak_valid", 64'(bus.peak_valid), 64'd0);
        check("reset_frame_err",  64'(bus.frame_err),  64'd0);

        // Long holds, bin 3 strongest; pin peak_valid latency explicitly
        re_v = '{1, 1, 1, 100, 1, 1, 1, 1};
        im_v = '{0, 0, 0, -50, 0, 0, 0, 0};
        v0 = valid_cnt;
        for (int b = 0; b < 7; b++) send(b, re_v[b], im_v[b], 26);
        step(1'b0, 7, 1, 0);
        check("lat_edge0_valid", 64'(bus.peak_valid), 64'd0);
        step(1'b0, 7, 1, 0);
        check("lat_edge1_valid", 64'(bus.peak_valid), 64'd1);
        step(1'b0, 7, 1, 0);
        check("lat_edge2_valid", 64'(bus.peak_valid), 64'd0);
        send(7, 1, 0, 23);
        check("t1_peak_index", 64'(bus.peak_index), 64'd3);
        check("t1_peak_mag",   64'(bus.peak_mag),   64'd12500);
        check("t1_valid_count", 64'(valid_cnt - v0), 64'd1);

        // Tie between bins 2 and 6 keeps bin 2
        re_v = '{0, 0, 30, 0, 0, 0, 30, 0};
        im_v = '{0, 0, 40, 0, 0, 0, 40, 0};
        send_frame(re_v, im_v, 3);
        idle(2);
        check("t2_peak_index", 64'(bus.peak_index), 64'd2);
        check("t2_peak_mag",   64'(bus.peak_mag),   64'd2500);

        // Most negative sample, one-cycle bins back to back
        re_v = '{0, 0, 0, 0, 0, -128, 0, 0};
        im_v = '{0, 0, 0, 0, 0, -128, 0, 0};
        send_frame(re_v, im_v, 1);
        idle(3);
        check("t3_peak_index", 64'(bus.peak_index), 64'd5);
        check("t3_peak_mag",   64'(bus.peak_mag),   64'd32768);
        check("t3_no_frame_err", 64'(err_cnt), 64'd0);

        // Broken sequence 0,1,2,4: one error, then SYNC until the next 0
        e0 = err_cnt; v0 = valid_cnt;
        send(0, 9, 0, 2); send(1, 9, 0, 2); send(2, 9, 0, 2);
        send(4, 9, 0, 2); send(5, 9, 0, 2); send(6, 9, 0, 2); send(7, 9, 0, 2);
        idle(3);
        check("t4_err_count",  64'(err_cnt - e0),   64'd1);
        check("t4_no_valid",   64'(valid_cnt - v0), 64'd0);
        check("t4_peak_held",  64'(bus.peak_mag),   64'd32768);
        re_v = '{0, 50, 0, 0, 0, 0, 0, 0};
        im_v = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(re_v, im_v, 2);
        idle(3);
        check("t4_recover_index", 64'(bus.peak_index), 64'd1);
        check("t4_recover_mag",   64'(bus.peak_mag),   64'd2500);
        check("t4_recover_valid", 64'(valid_cnt - v0), 64'd1);

        // Unexpected 0 mid-frame: error, and the 0 opens a fresh frame
        e0 = err_cnt; v0 = valid_cnt;
        send(0, 60, 0, 2); send(1, 60, 0, 2); send(2, 60, 0, 2);
        re_v = '{0, 0, 0, 0, 0, 0, 0, 0};
        im_v = '{0, 0, 0, 0, -7, 0, 0, 0};
        send_frame(re_v, im_v, 2);
        idle(3);
        check("t4b_err_count", 64'(err_cnt - e0),   64'd1);
        check("t4b_valid",     64'(valid_cnt - v0), 64'd1);
        check("t4b_peak_index", 64'(bus.peak_index), 64'd4);
        check("t4b_peak_mag",   64'(bus.peak_mag),   64'd49);

        // Reset during bin 4
        v0 = valid_cnt;
        send(0, 20, 0, 2); send(1, 0, 0, 2); send(2, 0, 0, 2); send(3, 0, 0, 2);
        send(4, 0, 0, 3);
        step(1'b1, 4, 0, 0);
        check("t5_rst_peak_index", 64'(bus.peak_index), 64'd0);
        check("t5_rst_peak_mag",   64'(bus.peak_mag),   64'd0);
        step(1'b1, 4, 0, 0);
        send(4, 0, 0, 2); send(5, 0, 0, 2); send(6, 0, 0, 2); send(7, 0, 0, 2);
        idle(3);
        check("t5_no_valid",  64'(valid_cnt - v0), 64'd0);
        check("t5_mag_zero",  64'(bus.peak_mag),   64'd0);
        re_v = '{0, 0, 20, 0, 0, 0, 0, 0};
        im_v = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(re_v, im_v, 2);
        idle(3);
        check("t5_after_index", 64'(bus.peak_index), 64'd2);
        check("t5_after_mag",   64'(bus.peak_mag),   64'd400);
        check("t5_after_valid", 64'(valid_cnt - v0), 64'd1);

        // Mirror-bin case: bin 6 strong, bin 1 weak
        re_v = '{0, 10, 0, 0, 0, 0, 90, 0};
        im_v = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(re_v, im_v, 2);
        idle(3);
`ifdef FFT_PEAK_HALF_SPECTRUM_EN
        check("t6_peak_index", 64'(bus.peak_index), 64'd1);
        check("t6_peak_mag",   64'(bus.peak_mag),   64'd100);
`else
        check("t6_peak_index", 64'(bus.peak_index), 64'd6);
        check("t6_peak_mag",   64'(bus.peak_mag),   64'd8100);
`endif

        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
